// File: rtl/axi4_lite_slave_write_q.sv
// rtl/axi4_lite_slave_write_q.sv - AXI4-Lite write slave with queued AW/W channels and a single-port memory write side
// Optional address window check: define AXI4_LITE_SLAVE_WRITE_Q_RANGE_CHECK_EN.
module axi4_lite_slave_write_q #(
   parameter int                        AXI_ADDR_WIDTH = 64,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter int                        FIFO_DEPTH     = 4,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter logic [AXI_ADDR_WIDTH:0]   SIZE_BYTES     = 'h10000
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic                          AW_VALID,
   output logic                          AW_READY,
   input  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
   input  logic [2:0]                    AW_PROT,
   input  logic                          W_VALID,
   output logic                          W_READY,
   input  logic [AXI_DATA_WIDTH-1:0]     W_DATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
   output logic                          B_VALID,
   input  logic                          B_READY,
   output logic [1:0]                    B_RESP,
   output logic                          mem_req_o,
   output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]     mem_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   mem_strb_o,
   input  logic                          mem_ack_i,
   input  logic                          mem_err_i
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WENT_W = AXI_DATA_WIDTH + STRB_W;
   localparam logic [CNT_W-1:0]          FULL_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(AXI_ADDR_WIDTH'(STRB_W - 1));
   localparam logic [AXI_ADDR_WIDTH:0]   LIMIT      = {1'b0, BASE_ADDR} + SIZE_BYTES;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t state_q, state_d;
   logic [1:0] resp_d;

   // AW queue
   logic [AXI_ADDR_WIDTH-1:0] aw_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          aw_wptr, aw_rptr;
   logic [CNT_W-1:0]          aw_count;
   logic                      aw_push;

   // W queue, entries are {data, strb}
   logic [WENT_W-1:0]         w_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          w_wptr, w_rptr;
   logic [CNT_W-1:0]          w_count;
   logic                      w_push;

   logic                      pop;
   logic [AXI_ADDR_WIDTH-1:0] head_addr;
   logic [AXI_DATA_WIDTH-1:0] head_data;
   logic [STRB_W-1:0]         head_strb;
   logic                      in_range;
   logic                      unused_sink;

   assign AW_READY = (aw_count != FULL_CNT);
   assign W_READY  = (w_count  != FULL_CNT);
   assign aw_push  = AW_VALID & AW_READY;
   assign w_push   = W_VALID & W_READY;
   assign pop      = (state_q == S_IDLE) && (aw_count != '0) && (w_count != '0);

   assign head_addr              = aw_mem[aw_rptr];
   assign {head_data, head_strb} = w_mem[w_rptr];
   assign in_range = (head_addr >= BASE_ADDR) && ({1'b0, head_addr} < LIMIT);
   assign unused_sink = ^{AW_PROT, in_range};

   always_ff @(posedge clk_i) begin
      if (aw_push) aw_mem[aw_wptr] <= AW_ADDR;
      if (w_push)  w_mem[w_wptr]   <= {W_DATA, W_STRB};
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         aw_wptr  <= '0;
         aw_rptr  <= '0;
         aw_count <= '0;
      end else begin
         if (aw_push) aw_wptr <= aw_wptr + 1'b1;
         if (pop)     aw_rptr <= aw_rptr + 1'b1;
         case ({aw_push, pop})
            2'b10:   aw_count <= aw_count + 1'b1;
            2'b01:   aw_count <= aw_count - 1'b1;
            default: aw_count <= aw_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         w_wptr  <= '0;
         w_rptr  <= '0;
         w_count <= '0;
      end else begin
         if (w_push) w_wptr <= w_wptr + 1'b1;
         if (pop)    w_rptr <= w_rptr + 1'b1;
         case ({w_push, pop})
            2'b10:   w_count <= w_count + 1'b1;
            2'b01:   w_count <= w_count - 1'b1;
            default: w_count <= w_count;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      resp_d  = B_RESP;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (head_strb == '0) begin
                  state_d = S_RESP;
                  resp_d  = 2'b00;
`ifdef AXI4_LITE_SLAVE_WRITE_Q_RANGE_CHECK_EN
               end else if (!in_range) begin
                  state_d = S_RESP;
                  resp_d  = 2'b11;
`endif
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (mem_ack_i) begin
               state_d = S_RESP;
               resp_d  = mem_err_i ? 2'b10 : 2'b00;
            end
         end
         S_RESP: begin
            if (B_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next-state decode.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= S_IDLE;
         B_VALID    <= 1'b0;
         B_RESP     <= 2'b00;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         mem_strb_o <= '0;
      end else begin
         state_q   <= state_d;
         B_VALID   <= (state_d == S_RESP);
         B_RESP    <= resp_d;
         mem_req_o <= (state_d == S_ISSUE);
         if (pop && (state_d == S_ISSUE)) begin
            mem_addr_o <= head_addr & ALIGN_MASK;
            mem_data_o <= head_data;
            mem_strb_o <= head_strb;
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_write_q.sv
// tb/tb_axi4_lite_slave_write_q.sv - directed self-checking bench for axi4_lite_slave_write_q
module tb_axi4_lite_slave_write_q;

   logic        clk_i = 1'b0;
   logic        arst_i;
   logic        AW_VALID, AW_READY;
   logic [63:0] AW_ADDR;
   logic [2:0]  AW_PROT;
   logic        W_VALID, W_READY;
   logic [31:0] W_DATA;
   logic [3:0]  W_STRB;
   logic        B_VALID, B_READY;
   logic [1:0]  B_RESP;
   logic        mem_req_o;
   logic [63:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [3:0]  mem_strb_o;
   logic        mem_ack_i, mem_err_i;

   int total  = 0;
   int passed = 0;

   axi4_lite_slave_write_q #(
      .AXI_ADDR_WIDTH(64),
      .AXI_DATA_WIDTH(32),
      .FIFO_DEPTH    (4),
      .BASE_ADDR     (64'h0),
      .SIZE_BYTES    (65'h10000)
   ) dut (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .AW_VALID  (AW_VALID),
      .AW_READY  (AW_READY),
      .AW_ADDR   (AW_ADDR),
      .AW_PROT   (AW_PROT),
      .W_VALID   (W_VALID),
      .W_READY   (W_READY),
      .W_DATA    (W_DATA),
      .W_STRB    (W_STRB),
      .B_VALID   (B_VALID),
      .B_READY   (B_READY),
      .B_RESP    (B_RESP),
      .mem_req_o (mem_req_o),
      .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o),
      .mem_strb_o(mem_strb_o),
      .mem_ack_i (mem_ack_i),
      .mem_err_i (mem_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_aw(input logic [63:0] addr);
      int n = 0;
      while (AW_READY !== 1'b1 && n < 50) begin step(); n++; end
      check("aw_ready_wait", AW_READY, 1);
      AW_VALID = 1'b1; AW_ADDR = addr;
      step();
      AW_VALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      while (W_READY !== 1'b1 && n < 50) begin step(); n++; end
      check("w_ready_wait", W_READY, 1);
      W_VALID = 1'b1; W_DATA = data; W_STRB = strb;
      step();
      W_VALID = 1'b0;
   endtask

   task automatic send_both(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      while ((AW_READY !== 1'b1 || W_READY !== 1'b1) && n < 50) begin step(); n++; end
      check("both_ready_wait", {AW_READY, W_READY}, 2'b11);
      AW_VALID = 1'b1; AW_ADDR = addr;
      W_VALID  = 1'b1; W_DATA  = data; W_STRB = strb;
      step();
      AW_VALID = 1'b0; W_VALID = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_req_o !== 1'b1 && n < 50) begin step(); n++; end
      check("req_wait", mem_req_o, 1);
   endtask

   task automatic expect_write(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic err, input logic [1:0] resp);
      int n = 0;
      wait_req();
      check("mem_addr", mem_addr_o, addr);
      check("mem_data", mem_data_o, data);
      check("mem_strb", mem_strb_o, strb);
      mem_ack_i = 1'b1; mem_err_i = err;
      step();
      mem_ack_i = 1'b0; mem_err_i = 1'b0;
      check("req_drop", mem_req_o, 0);
      while (B_VALID !== 1'b1 && n < 50) begin step(); n++; end
      check("bvalid_wait", B_VALID, 1);
      check("bresp", B_RESP, resp);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      arst_i = 1'b1;
      AW_VALID = 0; AW_ADDR = '0; AW_PROT = 3'b000;
      W_VALID = 0; W_DATA = '0; W_STRB = '0;
      B_READY = 1'b1; mem_ack_i = 1'b0; mem_err_i = 1'b0;
      step(); step();

      check("rst_aw_ready", AW_READY, 1);
      check("rst_w_ready", W_READY, 1);
      check("rst_bvalid", B_VALID, 0);
      check("rst_bresp", B_RESP, 0);
      check("rst_req", mem_req_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_data", mem_data_o, 0);
      check("rst_strb", mem_strb_o, 0);
      arst_i = 1'b0;
      step();

      // single write, minimum latency
      AW_VALID = 1; AW_ADDR = 64'h100;
      W_VALID = 1; W_DATA = 32'hDEADBEEF; W_STRB = 4'hF;
      mem_ack_i = 1;
      step();
      AW_VALID = 0; W_VALID = 0;
      check("c1_req", mem_req_o, 0);
      step();
      check("c2_req", mem_req_o, 1);
      check("c2_addr", mem_addr_o, 64'h100);
      check("c2_data", mem_data_o, 32'hDEADBEEF);
      check("c2_strb", mem_strb_o, 4'hF);
      step();
      check("c3_bvalid", B_VALID, 1);
      check("c3_bresp", B_RESP, 2'b00);
      check("c3_req", mem_req_o, 0);
      mem_ack_i = 0;
      step();
      check("c4_bvalid", B_VALID, 0);

      // W leads AW by a full queue
      for (int i = 0; i < 4; i++) send_w(32'h1111_0000 + i, 4'hF);
      check("wlead_w_full", W_READY, 0);
      check("wlead_aw_ready", AW_READY, 1);
      for (int i = 0; i < 4; i++) send_aw(64'h200 + 4 * i);
      for (int i = 0; i < 4; i++) expect_write(64'h200 + 4 * i, 32'h1111_0000 + i, 4'hF, 1'b0, 2'b00);

      // memory backpressure with stable outputs, queues fill meanwhile
      send_both(64'h400, 32'hCAFEF00D, 4'h3);
      wait_req();
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_req", mem_req_o, 1);
         check("bp_addr", mem_addr_o, 64'h400);
         check("bp_data", mem_data_o, 32'hCAFEF00D);
      end
      for (int i = 0; i < 4; i++) send_both(64'h500 + 4 * i, 32'h5555_0000 + i, 4'hF);
      check("full_aw_ready", AW_READY, 0);
      check("full_w_ready", W_READY, 0);
      check("full_req_held", mem_req_o, 1);

      // slave error plus response backpressure
      B_READY = 0;
      mem_ack_i = 1; mem_err_i = 1;
      step();
      mem_ack_i = 0; mem_err_i = 0;
      for (int i = 0; i < 5; i++) begin
         check("bbp_bvalid", B_VALID, 1);
         check("bbp_bresp", B_RESP, 2'b10);
         step();
      end
      B_READY = 1;
      step();
      check("bbp_release", B_VALID, 0);
      for (int i = 0; i < 4; i++) expect_write(64'h500 + 4 * i, 32'h5555_0000 + i, 4'hF, 1'b0, 2'b00);

      // zero strobe skips memory
      send_both(64'h600, 32'h12345678, 4'h0);
      check("zs_c1_req", mem_req_o, 0);
      step();
      check("zs_c2_bvalid", B_VALID, 1);
      check("zs_c2_bresp", B_RESP, 2'b00);
      check("zs_c2_req", mem_req_o, 0);
      step();
      check("zs_c3_bvalid", B_VALID, 0);

      // unaligned address is word-aligned on the memory side
      send_both(64'h103, 32'h0BADCAFE, 4'h1);
      expect_write(64'h100, 32'h0BADCAFE, 4'h1, 1'b0, 2'b00);

`ifdef AXI4_LITE_SLAVE_WRITE_Q_RANGE_CHECK_EN
      send_both(64'h10000, 32'hAAAA5555, 4'hF);
      check("rc_c1_req", mem_req_o, 0);
      step();
      check("rc_bvalid", B_VALID, 1);
      check("rc_bresp", B_RESP, 2'b11);
      check("rc_req", mem_req_o, 0);
      step();
      send_both(64'hFFFC, 32'h5555AAAA, 4'hF);
      expect_write(64'hFFFC, 32'h5555AAAA, 4'hF, 1'b0, 2'b00);
`else
      send_both(64'h10000, 32'hAAAA5555, 4'hF);
      expect_write(64'h10000, 32'hAAAA5555, 4'hF, 1'b0, 2'b00);
`endif

      // reset while issuing with two writes buffered
      send_both(64'h700, 32'h7777_0000, 4'hF);
      wait_req();
      send_both(64'h704, 32'h7777_0001, 4'hF);
      send_both(64'h708, 32'h7777_0002, 4'hF);
      #2 arst_i = 1'b1;
      #1;
      check("mr_req", mem_req_o, 0);
      check("mr_bvalid", B_VALID, 0);
      check("mr_aw_ready", AW_READY, 1);
      check("mr_w_ready", W_READY, 1);
      check("mr_addr", mem_addr_o, 0);
      step();
      arst_i = 1'b0;
      mem_ack_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (mem_req_o !== 1'b0 || B_VALID !== 1'b0) seen = 1'b1;
      end
      check("mr_no_stale", seen, 0);
      mem_ack_i = 1'b0;
      send_both(64'h800, 32'h8888_8888, 4'hC);
      expect_write(64'h800, 32'h8888_8888, 4'hC, 1'b0, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/axi4_lite_slave_write_q.md
# axi4_lite_slave_write_q

AXI4-Lite write slave with independently buffered address and data channels, byte-strobe forwarding and error responses. It sits between an AXI4-Lite write master and a single-port memory or register-file write port. AW and W are accepted in any order and may run up to FIFO_DEPTH transactions ahead of the memory side. One write is issued to memory at a time, and one B response is returned per write.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 64: address width.
- AXI_DATA_WIDTH, 32: data width; 32 or 64.
- FIFO_DEPTH, 4: entries per AW and W FIFO; power of two, ≥2.
- BASE_ADDR, 0: lowest legal byte address (used only with the range check).
- SIZE_BYTES, 'h10000: size of the legal window in bytes (used only with the range check).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset; asynchronous, active-high.
- AW_VALID/AW_READY  in/out  1  address handshake.
- AW_ADDR  in  AXI_ADDR_WIDTH  write byte address.
- AW_PROT  in  3  ignored.
- W_VALID/W_READY  in/out  1  data handshake.
- W_DATA  in  AXI_DATA_WIDTH  write data.
- W_STRB  in  AXI_DATA_WIDTH/8  byte enables.
- B_VALID  out  1  response valid.
- B_READY  in  1  response accepted.
- B_RESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR.
- mem_req_o  out  1  memory write request; held until acknowledged.
- mem_addr_o  out  AXI_ADDR_WIDTH  word-aligned address; low log2(AXI_DATA_WIDTH/8) bits forced to 0.
- mem_data_o  out  AXI_DATA_WIDTH  write data.
- mem_strb_o  out  AXI_DATA_WIDTH/8  byte enables.
- mem_ack_i  in  1  write done; sampled only while mem_req_o is 1.
- mem_err_i  in  1  write failed; valid together with mem_ack_i.

## Operation
- **AW FIFO:** pushes on AW_VALID&AW_READY. AW_READY = (aw_count != FIFO_DEPTH).
- **W FIFO:** pushes {W_DATA, W_STRB} on W_VALID&W_READY. W_READY = (w_count != FIFO_DEPTH).
- **FIFO pointers:** log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits.
- **Push and pop in the same cycle:** count is unchanged. This is legal at any occupancy, including 1. A push never occurs while full because READY is low.
- **State machine:** IDLE, ISSUE, RESP.
- **IDLE:**
  - Stays in IDLE unless both FIFOs are non-empty.
  - When both are non-empty: pops both FIFOs in the same cycle and registers address, data and strobe.
  - If strobe == 0: goes to RESP with B_RESP=00. No memory access occurs.
  - If the address is out of range (range-check build only): goes to RESP with B_RESP=11. No memory access occurs.
  - Otherwise: goes to ISSUE.
- **ISSUE:**
  - mem_req_o=1, with mem_addr_o, mem_data_o and mem_strb_o stable.
  - On mem_ack_i: B_RESP = mem_err_i ? 10 : 00, then go to RESP.
- **RESP:**
  - B_VALID=1, with B_RESP stable.
  - On B_READY: go to IDLE.
- **AW/W ordering:** AW and W are matched purely by FIFO order. Either channel may lead the other by up to FIFO_DEPTH beats.
- **Reset (asynchronous, any time):**
  - State returns to IDLE and FIFO pointers and counts clear; in-flight and buffered writes are discarded.
  - B_VALID=0, B_RESP=00, mem_req_o=0.
  - mem_addr_o, mem_data_o and mem_strb_o are set to 0.
  - AW_READY=1 and W_READY=1 (FIFOs empty).

## Timing
- All outputs are registered except AW_READY and W_READY, which decode from registered counts.
- Minimum latency, with both FIFOs empty and AW and W handshaking in cycle 0:
  - Pop in cycle 1.
  - mem_req_o=1 in cycle 2.
  - With mem_ack_i=1 in cycle 2, B_VALID=1 in cycle 3.
- Zero-strobe or DECERR writes: B_VALID=1 in cycle 2.
- Throughput: at most one write per 3 cycles once buffers are primed (IDLE→ISSUE→RESP, with ack and B_READY both same-cycle).
- mem_req_o deasserts in the cycle after the mem_ack_i cycle. B_VALID deasserts in the cycle after the B_READY cycle.
- B_VALID never depends combinationally on B_READY.

## Configuration
- Macro: AXI4_LITE_SLAVE_WRITE_Q_RANGE_CHECK_EN.
- Defined: an address is out of range when AW_ADDR < BASE_ADDR or AW_ADDR ≥ BASE_ADDR+SIZE_BYTES. Such a write is popped, produces no mem_req_o, and returns B_RESP=11.
- Undefined: no range check; every address with non-zero strobe is forwarded to memory. BASE_ADDR and SIZE_BYTES are unused.

## Test plan
- **Single write:** AW 0x100 and W 0xDEADBEEF with strb 0xF in the same cycle, ack the next cycle → mem_addr_o=0x100, mem_data_o=0xDEADBEEF, mem_strb_o=0xF; B_RESP=00 in cycle 3.
- **W leads AW:** 4 W beats first, then 4 AW beats (FIFO_DEPTH=4) → W_READY=0 after the 4th W beat; 4 memory writes in FIFO order; 4 OKAY responses.
- **Backpressure:**
  - mem_ack_i held low for 10 cycles → mem_req_o stays 1 with stable outputs.
  - B_READY held low for 5 cycles → B_VALID stays 1 with stable B_RESP.
  - FIFOs fill and both READYs drop.
- **Error paths:**
  - mem_err_i=1 with ack → B_RESP=10.
  - strb=0 → no mem_req_o, B_RESP=00.
  - With RANGE_CHECK_EN and BASE_ADDR=0, SIZE_BYTES=0x10000: address 0x10000 → no mem_req_o, B_RESP=11.
  - Same build, address 0xFFFC → forwarded.
- **Unaligned address:** AW 0x103 → mem_addr_o=0x100.
- **Reset mid-flight:** arst_i pulsed while in ISSUE with 2 entries buffered → mem_req_o=0, B_VALID=0, READYs=1; no stale write issued after release.
